// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the 8x8 register file: round-robin ALU/load arbitration plus a
// hold-aware clear sequence. Define REGFILE_WB_R0_LOCK_EN to make r0 writable only by clear.
module regfile_wb_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clka,
  input  logic              reset_in,
  input  logic              alu_req_in,
  input  logic [ADDR_W-1:0] alu_rd_in,
  input  logic [DATA_W-1:0] alu_data_in,
  output logic              alu_ack_out,
  input  logic              mem_req_in,
  input  logic [ADDR_W-1:0] mem_rd_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_ack_out,
  input  logic              clear_req_in,
  input  logic              hold_in,
  output logic              clear_busy_out,
  output logic              we_reg_out,
  output logic [ADDR_W-1:0] rd_out,
  output logic [DATA_W-1:0] data_out,
  output logic              last_mem_out
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_mem_q, last_mem_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              grant_alu, grant_mem;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_mem_d = last_mem_q;
    we_d       = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    grant_alu  = 1'b0;
    grant_mem  = 1'b0;
    win_rd     = '0;
    win_data   = '0;
    unique case (state_q)
      StIdle: begin
        if (!hold_in) begin
          if (clear_req_in) begin
            state_d = StClear;
            cnt_d   = '0;
          end else begin
            // On a tie the requester that did not win last time gets the port.
            grant_mem = mem_req_in & (~alu_req_in | ~last_mem_q);
            grant_alu = alu_req_in & ~grant_mem;
            win_rd    = grant_mem ? mem_rd_in : alu_rd_in;
            win_data  = grant_mem ? mem_data_in : alu_data_in;
            if (grant_mem || grant_alu) begin
              last_mem_d = grant_mem;
`ifdef REGFILE_WB_R0_LOCK_EN
              if (win_rd != '0) begin
                we_d   = 1'b1;
                rd_d   = win_rd;
                data_d = win_data;
              end
`else
              we_d   = 1'b1;
              rd_d   = win_rd;
              data_d = win_data;
`endif
            end
          end
        end
      end
      StClear: begin
        if (!hold_in) begin
          we_d   = 1'b1;
          rd_d   = cnt_q;
          data_d = '0;
          cnt_d  = cnt_q + ADDR_W'(1);
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_mem_q <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_mem_q <= last_mem_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  assign alu_ack_out    = grant_alu & ~reset_in;
  assign mem_ack_out    = grant_mem & ~reset_in;
  assign clear_busy_out = (state_q == StClear);
  assign we_reg_out     = we_q;
  assign rd_out         = rd_q;
  assign data_out       = data_q;
  assign last_mem_out   = last_mem_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus randomized arbitration
// against a rule-level reference model.
module tb_regfile_wb_ctrl;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       alu_req = 1'b0, mem_req = 1'b0, clear_req = 1'b0, hold = 1'b0;
  logic [2:0] alu_rd = '0, mem_rd = '0;
  logic [7:0] alu_data = '0, mem_data = '0;
  logic       alu_ack, mem_ack, busy, we, last_mem;
  logic [2:0] rd;
  logic [7:0] data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
    .clka(clk), .reset_in(reset_in),
    .alu_req_in(alu_req), .alu_rd_in(alu_rd), .alu_data_in(alu_data), .alu_ack_out(alu_ack),
    .mem_req_in(mem_req), .mem_rd_in(mem_rd), .mem_data_in(mem_data), .mem_ack_out(mem_ack),
    .clear_req_in(clear_req), .hold_in(hold), .clear_busy_out(busy),
    .we_reg_out(we), .rd_out(rd), .data_out(data), .last_mem_out(last_mem)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; alu_req = 1'b1; mem_req = 1'b1; clear_req = 1'b1;
    next_cycle();
    next_cycle();
    total++;
    if ({alu_ack, mem_ack} !== 2'b00) begin
      bad++; $display("FAIL reset_acks: got %b want 00", {alu_ack, mem_ack});
    end
    total++;
    if ({we, rd, data, last_mem, busy} !== 14'd0) begin
      bad++; $display("FAIL reset_outputs: got we=%b rd=%0d data=%h last=%b busy=%b want all 0",
                      we, rd, data, last_mem, busy);
    end
    reset_in = 1'b0; alu_req = 1'b0; mem_req = 1'b0; clear_req = 1'b0;
  endtask

  task automatic test_round_robin();
    alu_req = 1'b1; alu_rd = 3'd3; alu_data = 8'h5A;
    mem_req = 1'b1; mem_rd = 3'd5; mem_data = 8'hA5;
    #1;
    total++;
    if ({alu_ack, mem_ack} !== 2'b01) begin
      bad++; $display("FAIL rr_first_grant: got alu=%b mem=%b want alu=0 mem=1", alu_ack, mem_ack);
    end
    next_cycle();
    mem_req = 1'b0;
    #1;
    total++;
    if ({alu_ack, mem_ack} !== 2'b10) begin
      bad++; $display("FAIL rr_second_grant: got alu=%b mem=%b want alu=1 mem=0", alu_ack, mem_ack);
    end
    total++;
    if ({we, rd, data, last_mem} !== {1'b1, 3'd5, 8'hA5, 1'b1}) begin
      bad++; $display("FAIL rr_mem_write: got we=%b rd=%0d data=%h last=%b want 1 5 a5 1",
                      we, rd, data, last_mem);
    end
    next_cycle();
    alu_req = 1'b0;
    total++;
    if ({we, rd, data, last_mem} !== {1'b1, 3'd3, 8'h5A, 1'b0}) begin
      bad++; $display("FAIL rr_alu_write: got we=%b rd=%0d data=%h last=%b want 1 3 5a 0",
                      we, rd, data, last_mem);
    end
    next_cycle();
    total++;
    if ({we, rd, data} !== {1'b0, 3'd3, 8'h5A}) begin
      bad++; $display("FAIL rr_idle_hold: got we=%b rd=%0d data=%h want 0 3 5a", we, rd, data);
    end
  endtask

  task automatic test_clear_collision();
    clear_req = 1'b1;
    alu_req = 1'b1; alu_rd = 3'd6; alu_data = 8'h33;
    #1;
    total++;
    if ({alu_ack, mem_ack} !== 2'b00) begin
      bad++; $display("FAIL clr_no_ack_N: got alu=%b mem=%b want 0 0", alu_ack, mem_ack);
    end
    for (int k = 1; k <= 9; k++) begin
      logic       exp_we;
      logic [2:0] exp_rd;
      next_cycle();
      clear_req = 1'b0;
      exp_we = (k >= 2);
      exp_rd = 3'(k - 2);
      total++;
      if (busy !== (k <= 8)) begin
        bad++; $display("FAIL clr_busy_N+%0d: got %b want %b", k, busy, (k <= 8));
      end
      total++;
      if (we !== exp_we || (exp_we && (rd !== exp_rd || data !== 8'h00))) begin
        bad++; $display("FAIL clr_write_N+%0d: got we=%b rd=%0d data=%h want we=%b rd=%0d data=00",
                        k, we, rd, data, exp_we, exp_rd);
      end
      total++;
      if (alu_ack !== (k == 9)) begin
        bad++; $display("FAIL clr_alu_ack_N+%0d: got %b want %b", k, alu_ack, (k == 9));
      end
    end
    next_cycle();
    alu_req = 1'b0;
    total++;
    if ({we, rd, data} !== {1'b1, 3'd6, 8'h33}) begin
      bad++; $display("FAIL clr_after_write: got we=%b rd=%0d data=%h want 1 6 33", we, rd, data);
    end
  endtask

  task automatic test_hold_clear();
    int busy_cnt = 0;
    int wr_cnt[8];
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    clear_req = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      next_cycle();
      clear_req = 1'b0;
      hold = (k == 4 || k == 5);
      #1;
      if (busy) busy_cnt++;
      if (we) begin
        wr_cnt[rd]++;
        total++;
        if (data !== 8'h00) begin
          bad++; $display("FAIL hold_clr_data: got %h want 00 at rd=%0d", data, rd);
        end
      end
    end
    hold = 1'b0;
    total++;
    if (busy_cnt != 10) begin
      bad++; $display("FAIL hold_clr_busy_len: got %0d want 10", busy_cnt);
    end
    for (int r = 0; r < 8; r++) begin
      total++;
      if (wr_cnt[r] != 1) begin
        bad++; $display("FAIL hold_clr_r%0d_writes: got %0d want 1", r, wr_cnt[r]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int hi_writes = 0;
    clear_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      clear_req = 1'b0;
      if (we && rd >= 3'd4) hi_writes++;
      if (k == 5) reset_in = 1'b1;
    end
    next_cycle();
    reset_in = 1'b0;
    total++;
    if ({busy, we, rd, data, last_mem} !== 14'd0) begin
      bad++; $display("FAIL rst_mid_clr_out: got busy=%b we=%b rd=%0d data=%h last=%b want all 0",
                      busy, we, rd, data, last_mem);
    end
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (we) hi_writes++;
    end
    total++;
    if (hi_writes != 0) begin
      bad++; $display("FAIL rst_mid_clr_no_writes: got %0d writes want 0", hi_writes);
    end
  endtask

  task automatic test_r0();
    alu_req = 1'b1; alu_rd = 3'd0; alu_data = 8'hFF;
    #1;
    total++;
    if (alu_ack !== 1'b1) begin
      bad++; $display("FAIL r0_ack: got %b want 1", alu_ack);
    end
    next_cycle();
    alu_req = 1'b0;
`ifdef REGFILE_WB_R0_LOCK_EN
    total++;
    if ({we, rd, data} !== {1'b0, 3'd0, 8'h00}) begin
      bad++; $display("FAIL r0_locked: got we=%b rd=%0d data=%h want 0 0 00", we, rd, data);
    end
`else
    total++;
    if ({we, rd, data} !== {1'b1, 3'd0, 8'hFF}) begin
      bad++; $display("FAIL r0_write: got we=%b rd=%0d data=%h want 1 0 ff", we, rd, data);
    end
`endif
    total++;
    if (last_mem !== 1'b0) begin
      bad++; $display("FAIL r0_last_mem: got %b want 0", last_mem);
    end
  endtask

  task automatic test_random();
    logic       m_last = 1'b0, m_we = 1'b0;
    logic [2:0] m_rd = '0;
    logic [7:0] m_data = '0;
    logic       g_alu = 1'b0, g_mem = 1'b0;
    reset_in = 1'b1; alu_req = 1'b0; mem_req = 1'b0; hold = 1'b0;
    next_cycle();
    reset_in = 1'b0;
    for (int c = 0; c < 400; c++) begin
      total++;
      if ({we, rd, data, last_mem, busy} !== {m_we, m_rd, m_data, m_last, 1'b0}) begin
        bad++; $display("FAIL rand_out_c%0d: got we=%b rd=%0d data=%h last=%b busy=%b want %b %0d %h %b 0",
                        c, we, rd, data, last_mem, busy, m_we, m_rd, m_data, m_last);
      end
      // Requesters obey the contract: new request only once the previous one was accepted.
      if (!alu_req || g_alu) begin
        alu_req = 1'($urandom_range(0, 1)); alu_rd = 3'($urandom); alu_data = 8'($urandom);
      end
      if (!mem_req || g_mem) begin
        mem_req = 1'($urandom_range(0, 1)); mem_rd = 3'($urandom); mem_data = 8'($urandom);
      end
      hold = ($urandom_range(0, 4) == 0);
      #1;
      g_alu = 1'b0; g_mem = 1'b0;
      if (!hold) begin
        if (alu_req && mem_req) begin
          if (m_last) g_alu = 1'b1; else g_mem = 1'b1;
        end else begin
          g_alu = alu_req;
          g_mem = mem_req;
        end
      end
      total++;
      if ({alu_ack, mem_ack} !== {g_alu, g_mem}) begin
        bad++; $display("FAIL rand_ack_c%0d: got alu=%b mem=%b want alu=%b mem=%b",
                        c, alu_ack, mem_ack, g_alu, g_mem);
      end
      m_we = 1'b0;
      if (g_alu || g_mem) begin
        logic [2:0] w_rd;
        logic [7:0] w_data;
        m_last = g_mem;
        w_rd   = g_mem ? mem_rd : alu_rd;
        w_data = g_mem ? mem_data : alu_data;
`ifdef REGFILE_WB_R0_LOCK_EN
        if (w_rd != 3'd0) begin
          m_we = 1'b1; m_rd = w_rd; m_data = w_data;
        end
`else
        m_we = 1'b1; m_rd = w_rd; m_data = w_data;
`endif
      end
      next_cycle();
    end
    alu_req = 1'b0; mem_req = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_clear_collision();
    test_hold_clear();
    test_reset_mid_clear();
    test_r0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
